cpu_fetch_sequencer: RTL
========================

// Module: cpu_fetch_sequencer
// PURPOSE
// - Instruction-fetch and cycle sequencer upstream of the instruction decoder.
// - Owns the PC and the FETCH/EXEC1/EXEC2 cycle.
// - Issues instruction reads on the memory bus and latches the returned word (byte-swapped to MIPS order).
// - Drives fetch/exec_one/exec_two/current_instruction to the decoder.
// - Applies branch/jump redirects after one delay slot and halts on a jump to address 0.
// PARAMETERS
// - RESET_VECTOR  32'hBFC00000  PC value after reset
// - HALT_ADDR     32'h00000000  any new PC equal to this enters HALT
// - BYTE_SWAP     1             1: current_instruction = byte-reversed mem_readdata; 0: pass-through
// PORTS
// - clk                  in   1   single clock, all state on rising edge
// - reset_n              in   1   asynchronous, active-low reset
// - mem_waitrequest      in   1   bus not ready; read must be held
// - mem_readdata         in   32  instruction word from bus
// - ifetch_read          out  1   instruction read strobe
// - ifetch_address       out  32  byte address of read (= pc)
// - stall_exec2          in   1   data-side access incomplete; hold EXEC2
// - branch_req           in   1   redirect request, sampled only on EXEC2 exit cycle
// - branch_target        in   32  redirect address; bits [1:0] forced to 0
// - fetch                out  1   state==FETCH
// - exec_one             out  1   state==EXEC1
// - exec_two             out  1   state==EXEC2
// - current_instruction  out  32  latched instruction register
// - pc                   out  32  address of current instruction
// - active               out  1   0 only in HALT
// BEHAVIOUR
// - States: FETCH, EXEC1, EXEC2, HALT; strobes are one-hot decodes of state, all 0 in HALT.
// - Reset values (reset_n low):
//   - Outputs: state=FETCH, pc=RESET_VECTOR, current_instruction=0, active=1, ifetch_read=0.
//   - Internal: delay_pending=0, delay_target=0.
// - FETCH:
//   - ifetch_read=1, ifetch_address=pc.
//   - mem_waitrequest=1: stay; address held stable; IR unchanged.
//   - mem_waitrequest=0: at the edge, IR<=swap(mem_readdata), then EXEC1. Minimum fetch is 1 cycle.
// - EXEC1: exactly 1 cycle, then EXEC2; ifetch_read=0.
// - EXEC2 with stall_exec2=1: stay; pc, IR and pending state frozen.
// - EXEC2 exit (stall_exec2=0):
//   - new_pc = delay_pending ? delay_target : pc+4 (32-bit wrap, 0xFFFFFFFC+4=0).
//   - delay_pending<=0 when it was set.
//   - branch_req=1 and delay_pending=0: delay_pending<=1, delay_target<=target.
//   - branch_req=1 while delay_pending=1 (branch in delay slot): request ignored; pending redirect applied.
//   - new_pc==HALT_ADDR: pc<=HALT_ADDR, next state HALT; otherwise pc<=new_pc, next state FETCH.
// - HALT: absorbing until reset; active=0; ifetch_read=0; pc and IR hold.
// - Throughput: 3 cycles/instruction with no wait or stall.
// - Async reset mid-operation:
//   - Discards any in-flight read and any pending redirect.
//   - First read after release targets RESET_VECTOR.
// - current_instruction changes only on a FETCH exit edge.
// STRUCTURE
// - Shared package cpu_pkg holds:
//   - typedef enum logic [1:0] seq_state_t {FETCH, EXEC1, EXEC2, HALT}
//   - RESET_VECTOR default constant
//   - function byte_swap32
// - No sub-module: one state register, PC/IR/pending registers, one combinational next-state block.
// TESTING
// - Basic sequence: release reset, waitrequest=0, readdata=0x78563412
//   -> read at 0xBFC00000; IR=0x12345678; EXEC1, EXEC2; then FETCH with pc=0xBFC00004.
// - Wait states: waitrequest=1 for 3 cycles
//   -> fetch high 4 cycles; address steady at pc; IR updates only on the 4th edge.
// - Delay slot: branch_req=1, target=0xBFC00101 at EXEC2 of 0xBFC00000
//   -> next fetch 0xBFC00004, then 0xBFC00100.
// - Halt: target=0 at EXEC2 of 0xBFC00010
//   -> fetch 0xBFC00014; after its EXEC2: active=0, pc=0, ifetch_read=0 for 20+ cycles.
// - Stall: stall_exec2=1 for 2 cycles -> exec_two high 3 cycles; pc advances only on release.
// - Reset mid-operation: reset_n low during stalled EXEC2 with redirect pending
//   -> reset values immediately; after release, fetches run sequentially from 0xBFC00000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch/execute cycle states, reset constants and
// the bus-to-instruction byte-order helper.
package cpu_pkg;

  // Cycle phases of one instruction. HALT is absorbing until reset.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  // Boot ROM entry point used when the top is not overridden.
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC00000;

  // A new PC equal to this address stops the sequencer.
  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h00000000;

  // Sequential instruction step in bytes.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Instruction addresses are word aligned; the low two bits are always 0.
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Reverse the four bytes of a bus word (little-endian bus to MIPS order).
  function automatic logic [31:0] byte_swap32(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/cpu_fetch_sequencer.sv
// Instruction-fetch and cycle sequencer. Owns the PC and the
// FETCH -> EXEC1 -> EXEC2 cycle, reads instructions from the bus, latches
// them for the decoder and applies branch redirects after one delay slot.
// A jump to the halt address parks the sequencer in HALT until reset.
module cpu_fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR,
  parameter bit          BYTE_SWAP    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  // Instruction bus
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        ifetch_read,
  output logic [31:0] ifetch_address,
  // Execute-side control
  input  logic        stall_exec2,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  // Decoder interface
  output logic        fetch,
  output logic        exec_one,
  output logic        exec_two,
  output logic [31:0] current_instruction,
  output logic [31:0] pc,
  output logic        active
);

  // Architectural and sequencing state.
  seq_state_t  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_delay_pending;
  logic [31:0] r_delay_target;

  // Next-state values produced by the combinational block.
  seq_state_t  w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_ir_next;
  logic        w_pending_next;
  logic [31:0] w_target_next;

  // Helpers for the EXEC2 exit decision.
  logic [31:0] w_seq_pc;
  logic [31:0] w_new_pc;
  logic [31:0] w_fetch_word;
  logic        w_exec2_exit;

  // Bus word as the decoder wants to see it.
  assign w_fetch_word = BYTE_SWAP ? byte_swap32(mem_readdata) : mem_readdata;

  // Sequential successor wraps naturally at 32 bits (0xFFFFFFFC + 4 = 0).
  assign w_seq_pc = r_pc + PC_STEP;

  // A pending redirect from the previous instruction takes priority: the
  // current instruction was its delay slot.
  assign w_new_pc = r_delay_pending ? r_delay_target : w_seq_pc;

  // EXEC2 finishes only once the data side has released the stall.
  assign w_exec2_exit = (r_state == EXEC2) && !stall_exec2;

  // Next-state, PC, IR and redirect bookkeeping for the current cycle.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_ir_next      = r_ir;
    w_pending_next = r_delay_pending;
    w_target_next  = r_delay_target;

    case (r_state)
      FETCH: begin
        // Hold the address until the bus accepts; the IR is only written
        // on the edge that completes the read.
        if (!mem_waitrequest) begin
          w_ir_next    = w_fetch_word;
          w_state_next = EXEC1;
        end
      end

      EXEC1: begin
        w_state_next = EXEC2;
      end

      EXEC2: begin
        if (w_exec2_exit) begin
          if (r_delay_pending) begin
            // Redirect consumed this cycle; a branch sitting in the delay
            // slot is deliberately dropped.
            w_pending_next = 1'b0;
          end else if (branch_req) begin
            // Remember the target; it takes effect after the next
            // instruction (the delay slot) completes.
            w_pending_next = 1'b1;
            w_target_next  = branch_target & WORD_ALIGN_MASK;
          end

          w_pc_next    = w_new_pc;
          w_state_next = (w_new_pc == HALT_ADDR) ? HALT : FETCH;
        end
      end

      HALT: begin
        // Absorbing: PC, IR and redirect state all hold until reset.
        w_state_next = HALT;
      end
    endcase
  end

  // Single state/PC/IR register bank; reset abandons any in-flight read
  // and any pending redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= FETCH;
      r_pc            <= RESET_VECTOR;
      r_ir            <= 32'h0;
      r_delay_pending <= 1'b0;
      r_delay_target  <= 32'h0;
    end else begin
      r_state         <= w_state_next;
      r_pc            <= w_pc_next;
      r_ir            <= w_ir_next;
      r_delay_pending <= w_pending_next;
      r_delay_target  <= w_target_next;
    end
  end

  // Strobes are straight decodes of the state register; all low in HALT.
  assign fetch    = (r_state == FETCH);
  assign exec_one = (r_state == EXEC1);
  assign exec_two = (r_state == EXEC2);
  assign active   = (r_state != HALT);

  // The state register already sits in FETCH while reset is held, so the
  // read strobe is additionally gated by reset to keep the bus quiet.
  assign ifetch_read    = (r_state == FETCH) && reset_n;
  assign ifetch_address = r_pc;

  assign pc                  = r_pc;
  assign current_instruction = r_ir;

endmodule
